// File: rtl/sprite_blitter.sv
// Sprite blitter: walks every pixel of one sprite, fetches its colour from
// the sprite ROM and writes the opaque, on-screen pixels to the frame buffer
// through a valid/ready write port.
module sprite_blitter #(
  parameter int          SPR_W  = 21,
  parameter int          SPR_H  = 41,
  parameter int          SCR_W  = 640,
  parameter int          SCR_H  = 480,
  parameter logic [11:0] TRANSP = 12'h808
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        flip,
  output logic        busy,
  output logic        done,
  output logic [9:0]  rom_addr,
  input  logic [11:0] rom_color,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  input  logic        fb_ready
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {IDLE, READ, EMIT, FIN} state_t;

  state_t             state_reg;
  logic [COL_W-1:0]   col_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [10:0]        pos_x_reg;
  logic [10:0]        pos_y_reg;
  logic               flip_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               fb_we_reg;
  logic [18:0]        fb_addr_reg;
  logic [11:0]        fb_data_reg;

  logic [COL_W-1:0]   rom_col;
  logic [11:0]        sx_c;
  logic [11:0]        sy_c;
  logic               in_x;
  logic               in_y;
  logic               pix_draw;
  logic [18:0]        pix_addr;
  logic               last_pix;

  // ROM address (mirrored column when flipped) and the current pixel's screen
  // position, visibility and frame-buffer address, all evaluated in READ
  always_comb begin
    rom_col  = flip_reg ? (COL_W'(SPR_W - 1) - col_reg) : col_reg;
    rom_addr = (state_reg == READ) ? (10'(row_reg) * 10'(SPR_W) + 10'(rom_col)) : 10'd0;
    sx_c     = {pos_x_reg[10], pos_x_reg} + 12'(col_reg);
    sy_c     = {pos_y_reg[10], pos_y_reg} + 12'(row_reg);
    in_x     = !sx_c[11] && (sx_c[10:0] < 11'(SCR_W));
    in_y     = !sy_c[11] && (sy_c[10:0] < 11'(SCR_H));
    pix_draw = (rom_color != TRANSP) && in_x && in_y;
    pix_addr = 19'(sy_c[10:0]) * 19'(SCR_W) + 19'(sx_c[10:0]);
    last_pix = (row_reg == ROW_W'(SPR_H - 1)) && (col_reg == COL_W'(SPR_W - 1));
  end

  // Control FSM; the write-port outputs are loaded at the READ->EMIT edge so
  // that a drawn pixel is presented during its very first EMIT cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      pos_x_reg   <= '0;
      pos_y_reg   <= '0;
      flip_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      fb_we_reg   <= 1'b0;
      fb_addr_reg <= '0;
      fb_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pos_x_reg <= pos_x;
            pos_y_reg <= pos_y;
            flip_reg  <= flip;
            col_reg   <= '0;
            row_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          fb_we_reg <= pix_draw;
          if (pix_draw) begin
            fb_addr_reg <= pix_addr;
            fb_data_reg <= rom_color;
          end
          state_reg <= EMIT;
        end
        EMIT: begin
          // skipped pixels advance at once; drawn ones wait for the handshake
          if (!fb_we_reg || fb_ready) begin
            fb_we_reg <= 1'b0;
            if (last_pix) begin
              col_reg   <= '0;
              row_reg   <= '0;
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              state_reg <= READ;
              if (col_reg == COL_W'(SPR_W - 1)) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
            end
          end
        end
        FIN: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign fb_we   = fb_we_reg;
  assign fb_addr = fb_addr_reg;
  assign fb_data = fb_data_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed testbench for sprite_blitter: behavioural sprite ROM, write
// monitor and hand-computed expectations for each drawing scenario.
module tb_sprite_blitter;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        flip;
  logic        busy;
  logic        done;
  logic [9:0]  rom_addr;
  logic [11:0] rom_color;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_ready;

  int checks = 0;
  int errors = 0;

  // sprite ROM model: either fully transparent or colour == address
  logic        rom_opaque;
  logic [18:0] wr_addr [0:1023];
  logic [11:0] wr_data [0:1023];
  int          wr_cnt;
  int          done_cnt;
  int          lat;
  logic [18:0] hold_addr;
  logic [11:0] hold_data;

  sprite_blitter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .flip      (flip),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_color (rom_color),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ready  (fb_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // combinational ROM
  always_comb begin
    rom_color = rom_opaque ? 12'(rom_addr) : 12'h808;
  end

  // inputs change at posedge+1, so the negedge sees the values the next
  // posedge will act on: record accepted writes and done pulses
  always @(negedge Clk) begin
    if (!Reset) begin
      if (fb_we && fb_ready) begin
        if (wr_cnt < 1024) begin
          wr_addr[wr_cnt] = fb_addr;
          wr_data[wr_cnt] = fb_data;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // one-cycle start pulse; returns just after the accepting edge
  task automatic start_sprite(input logic [10:0] x, input logic [10:0] y, input logic f);
    @(posedge Clk); #1;
    pos_x = x; pos_y = y; flip = f; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // counts edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge Clk); #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic clear_log();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pos_x = '0; pos_y = '0; flip = 1'b0;
    fb_ready = 1'b1; rom_opaque = 1'b0;
    wr_cnt = 0; done_cnt = 0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_data), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    Reset = 1'b0;

    // fully transparent sprite: nothing written, 2 cycles per pixel
    clear_log();
    rom_opaque = 1'b0;
    start_sprite(11'd100, 11'd100, 1'b0);
    check("tr_busy", 32'(busy), 1);
    wait_done(lat);
    check("tr_done_lat", 32'(lat), 1722);
    @(posedge Clk); #1;
    check("tr_busy_after", 32'(busy), 0);
    check("tr_done_after", 32'(done), 0);
    check("tr_writes", 32'(wr_cnt), 0);
    check("tr_done_pulses", 32'(done_cnt), 1);

    // opaque, unflipped at the origin
    clear_log();
    rom_opaque = 1'b1;
    start_sprite(11'd0, 11'd0, 1'b0);
    wait_done(lat);
    check("op_done_lat", 32'(lat), 1722);
    @(posedge Clk); #1;
    check("op_writes", 32'(wr_cnt), 861);
    check("op_w0_addr", 32'(wr_addr[0]), 0);
    check("op_w0_data", 32'(wr_data[0]), 0);
    check("op_w21_addr", 32'(wr_addr[21]), 640);
    check("op_w21_data", 32'(wr_data[21]), 21);
    check("op_last_addr", 32'(wr_addr[860]), 25620);
    check("op_last_data", 32'(wr_data[860]), 860);

    // mirrored
    clear_log();
    start_sprite(11'd0, 11'd0, 1'b1);
    wait_done(lat);
    @(posedge Clk); #1;
    check("fl_writes", 32'(wr_cnt), 861);
    check("fl_w0_addr", 32'(wr_addr[0]), 0);
    check("fl_w0_data", 32'(wr_data[0]), 20);
    check("fl_w20_addr", 32'(wr_addr[20]), 20);
    check("fl_w20_data", 32'(wr_data[20]), 0);

    // clipped at left and bottom edges: pos = (-5, 470)
    clear_log();
    start_sprite(11'h7FB, 11'd470, 1'b0);
    wait_done(lat);
    @(posedge Clk); #1;
    check("cl_writes", 32'(wr_cnt), 160);
    check("cl_w0_addr", 32'(wr_addr[0]), 300800);
    check("cl_w0_data", 32'(wr_data[0]), 5);
    check("cl_last_addr", 32'(wr_addr[159]), 306575);
    check("cl_last_data", 32'(wr_data[159]), 209);

    // backpressure on the first pixel, pos = (3,2), flipped
    clear_log();
    fb_ready = 1'b0;
    start_sprite(11'd3, 11'd2, 1'b1);
    lat = 0;
    while (!fb_we && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("bp_we_rise", 32'(fb_we), 1);
    check("bp_addr", 32'(fb_addr), 1283);
    check("bp_data", 32'(fb_data), 20);
    hold_addr = fb_addr;
    hold_data = fb_data;
    for (int i = 1; i < 7; i++) begin
      if (i == 2) start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      check($sformatf("bp_hold_we_%0d", i), 32'(fb_we), 1);
      check($sformatf("bp_hold_addr_%0d", i), 32'(fb_addr), 32'(hold_addr));
      check($sformatf("bp_hold_data_%0d", i), 32'(fb_data), 32'(hold_data));
    end
    check("bp_no_write_yet", 32'(wr_cnt), 0);
    fb_ready = 1'b1;
    @(posedge Clk); #1;
    fb_ready = 1'b0;
    check("bp_we_drop", 32'(fb_we), 0);
    @(posedge Clk); #1;
    check("bp_one_write", 32'(wr_cnt), 1);
    check("bp_w0_addr", 32'(wr_addr[0]), 1283);
    fb_ready = 1'b1;
    wait_done(lat);
    check("bp_done_seen", 32'(done), 1);
    repeat (50) @(posedge Clk);
    #1;
    check("bp_writes", 32'(wr_cnt), 861);
    check("bp_done_pulses", 32'(done_cnt), 1);
    check("bp_idle", 32'(busy), 0);

    // asynchronous reset in the middle of a stalled write
    clear_log();
    fb_ready = 1'b0;
    start_sprite(11'd0, 11'd0, 1'b0);
    lat = 0;
    while (!fb_we && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("mr_we_before", 32'(fb_we), 1);
    #2;
    Reset = 1'b1;
    #1;
    check("mr_we", 32'(fb_we), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    fb_ready = 1'b1;
    @(posedge Clk); #1;
    check("mr_idle_busy", 32'(busy), 0);
    clear_log();
    start_sprite(11'd0, 11'd0, 1'b0);
    wait_done(lat);
    check("mr_restart_lat", 32'(lat), 1722);
    @(posedge Clk); #1;
    check("mr_restart_writes", 32'(wr_cnt), 861);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reader/consumer side of the on-chip sprite ROMs (10-bit read_address in, 12-bit palette color out, combinational read).
- On a start request, walks every pixel of one sprite, fetches its color from the sprite ROM and writes opaque pixels into the 640x480x12-bit frame buffer.
- Writes go through a valid/ready write port.
- Sits between the game-logic sprite scheduler and the frame-buffer arbiter.

Parameters:
- SPR_W, 21, sprite width in pixels.
- SPR_H, 41, sprite height in pixels. SPR_W*SPR_H must be <= 1024; the default 861 matches the ROM depth.
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- TRANSP, 12'h808, color treated as transparent (palette entry 0).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to draw a sprite; ignored while busy.
- pos_x  in  11  signed screen X of the sprite's top-left pixel; sampled on accepted start.
- pos_y  in  11  signed screen Y of the sprite's top-left pixel; sampled on accepted start.
- flip  in  1  1 = mirror horizontally (right-facing ROM drawn facing left); sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sprite is finished.
- rom_addr  out  10  sprite ROM read_address.
- rom_color  in  12  sprite ROM output_color, valid in the same cycle as rom_addr.
- fb_we  out  1  frame-buffer write valid.
- fb_addr  out  19  frame-buffer address, y*SCR_W + x.
- fb_data  out  12  pixel color.
- fb_ready  in  1  frame buffer accepts the write on a rising edge where fb_we && fb_ready.

Behaviour:
- Reset (async, any time, including mid-sprite):
  - state=IDLE; busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0.
  - Counters cleared. Any in-flight write is abandoned.
- FSM states: IDLE, READ, EMIT, FIN.
- IDLE:
  - start=1 latches pos_x, pos_y and flip, sets row=0 and col=0, then goes to READ.
  - start while not in IDLE is ignored (no queueing).
- READ (1 cycle):
  - rom_addr = row*SPR_W + (flip ? SPR_W-1-col : col).
  - rom_color is registered into col_q.
  - Screen coordinates are computed: sx = pos_x + col, sy = pos_y + row (12-bit signed arithmetic, no wrap).
  - Go to EMIT.
- EMIT, pixel is skipped when col_q == TRANSP, or sx < 0, or sx >= SCR_W, or sy < 0, or sy >= SCR_H:
  - fb_we stays 0; advance immediately (1 cycle in EMIT).
- EMIT, pixel is drawn otherwise:
  - fb_we=1, fb_addr = sy*SCR_W + sx, fb_data = col_q.
  - fb_we, fb_addr and fb_data are held stable while fb_ready=0.
  - On the edge with fb_ready=1: fb_we drops and the FSM advances.
- Advance:
  - col increments; at col == SPR_W-1, col wraps to 0 and row increments.
  - After pixel (SPR_H-1, SPR_W-1) go to FIN; otherwise go to READ.
- FIN (1 cycle): done=1, busy=0 next cycle, return to IDLE.
  - start in the FIN cycle is ignored.
  - start is accepted from the first IDLE cycle.
- Timing:
  - Minimum per pixel: 2 cycles (READ + EMIT), plus stall cycles while fb_ready=0.
  - Pixels are written in raster order: row-major, increasing screen x.
- Outputs are registered. rom_addr is the only output derived from state and counters combinationally.

Test Plan:
- Reset mid-draw: assert Reset during EMIT with fb_we=1 -> fb_we, busy and done are 0 immediately (asynchronous). After release the block is idle, and a new start is accepted.
- Fully transparent ROM (all 12'h808), pos=(100,100), fb_ready=1 -> zero fb_we pulses; done pulses exactly 1722 cycles after the start cycle.
- Opaque ROM with rom_color = address, pos=(0,0), flip=0, fb_ready=1:
  - 861 writes.
  - First write: fb_addr=0, fb_data=0.
  - Write 22: fb_addr=640, fb_data=21.
  - Last write: fb_addr=40*640+20=25620.
- Same ROM with flip=1 -> first write: fb_addr=0, fb_data=20. Write 21: fb_addr=20, fb_data=0.
- Clipping with pos=(-5,470), opaque ROM -> only pixels with col>=5 and row<=9 are written: 16*10=160 writes. Lowest fb_addr = 470*640+0 = 300800.
- Backpressure: fb_ready held 0 for 7 cycles on the first opaque pixel -> fb_we, fb_addr and fb_data are stable across all 7 cycles; exactly one write is accepted. A second start issued during busy causes no extra draw.
